// File: rtl/cgra_obi_master_arbiter_pkg.sv
// Shared constants and OBI channel types for the CGRA column-to-system-bus arbiter.
package cgra_obi_master_arbiter_pkg;

  localparam int N_COL               = 4;
  localparam int ARB_MAX_OUTSTANDING = 2;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  // Index width that stays at least one bit even for a single entry.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cgra_obi_master_arbiter_id_fifo.sv
// In-order FIFO of issuing column indices; the head names the column owed the next rvalid.
module cgra_id_fifo
  import cgra_obi_master_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = idxWidth(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full/empty come straight from the registered count, so a pop frees space only next cycle.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  assign doPush = push_i & ~full_o;
  assign doPop  = pop_i & ~empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = nextPtr(wrPtr_q);
    if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
    if (doPush && !doPop)      count_d = count_q + 1'b1;
    else if (doPop && !doPush) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/cgra_obi_master_arbiter.sv
// Round-robin arbiter merging the CGRA column OBI masters onto one system bus master,
// routing responses back to the issuing column in grant order.
module cgra_obi_master_arbiter
  import cgra_obi_master_arbiter_pkg::*;
#(
  parameter int N_REQ           = N_COL,
  parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING,
  parameter int ID_W            = idxWidth(N_REQ)
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  col_req_i  [N_REQ],
  output obi_resp_t col_resp_o [N_REQ],
  output obi_req_t  bus_req_o,
  input  obi_resp_t bus_resp_i,
  output logic      busy_o,
  output logic      err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [ID_W-1:0]  rrPtr_q, rrPtr_d;
  logic [ID_W-1:0]  lockIdx_q, lockIdx_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;

  logic [ID_W-1:0]  cand;
  logic             candValid;
  logic             issue, handshake, pop;
  logic [ID_W-1:0]  fifoHead;
  logic             fifoFull, fifoEmpty;
  logic [CNT_W-1:0] fifoCount;

  // Nearest requester at or after the pointer wins, unless a stalled request holds the lock.
  always_comb begin
    int slot;
    slot      = 0;
    cand      = rrPtr_q;
    candValid = 1'b0;
    if (lock_q) begin
      cand      = lockIdx_q;
      candValid = col_req_i[lockIdx_q].req;
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        slot = int'(rrPtr_q) + i;
        if (slot >= N_REQ) slot = slot - N_REQ;
        if (col_req_i[slot].req) begin
          cand      = ID_W'(slot);
          candValid = 1'b1;
        end
      end
    end
  end

  assign issue     = candValid & ~fifoFull & ~rst_i;
  assign handshake = issue & bus_resp_i.gnt;
  assign pop       = bus_resp_i.rvalid & ~fifoEmpty & ~rst_i;

  assign bus_req_o = issue ? col_req_i[cand] : '0;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) col_resp_o[k] = '0;
    if (handshake) col_resp_o[cand].gnt = 1'b1;
    if (pop) begin
      col_resp_o[fifoHead].rvalid = 1'b1;
      col_resp_o[fifoHead].rdata  = bus_resp_i.rdata;
    end
  end

  // A stalled request keeps the lock; a handshake or a dropped req both release it.
  always_comb begin
    rrPtr_d   = rrPtr_q;
    lock_d    = issue & ~bus_resp_i.gnt;
    lockIdx_d = lockIdx_q;
    err_d     = err_q | (bus_resp_i.rvalid & fifoEmpty);
    if (lock_d) lockIdx_d = cand;
    if (handshake) rrPtr_d = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rrPtr_q   <= '0;
      lock_q    <= 1'b0;
      lockIdx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rrPtr_q   <= rrPtr_d;
      lock_q    <= lock_d;
      lockIdx_q <= lockIdx_d;
      err_q     <= err_d;
    end
  end

  cgra_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_idFifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (cand),
    .pop_i   (pop),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign busy_o = (fifoCount != '0) | lock_q;
  assign err_o  = err_q;

endmodule
